piso_tx_ctrl: RTL
=================

// Module: piso_tx_ctrl
// PURPOSE
//   Sequencing controller wrapped around a WIDTH-bit parallel-in/serial-out shift register.
//   Accepts parallel words over a valid/ready handshake and shifts each word out LSB first.
//   Paces the output with a downstream ready signal and marks frame boundaries.
//   Inserts a programmable idle gap between frames. Sits between a word producer and a serial link/driver.
// PARAMETERS
//   WIDTH       4  bits per frame; legal range >= 2
//   GAP_CYCLES  1  idle cycles after the last bit before the next word is accepted; 0 = back-to-back
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      synchronous, active-low reset
//   in_valid   in   1      producer has a word on in_data
//   in_data    in   WIDTH  parallel word, sampled only on accept
//   in_ready   out  1      controller can accept a word this cycle
//   ser_ready  in   1      downstream consumes the current bit this cycle
//   ser_out    out  1      current serial bit
//   ser_valid  out  1      ser_out holds a valid frame bit
//   ser_first  out  1      current bit is bit 0 of the frame
//   ser_last   out  1      current bit is bit WIDTH-1 of the frame
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse after the last bit is consumed
//   abort      in   1      synchronous frame cancel
// BEHAVIOUR
//   - Reset (reset_n=0 at a clk edge):
//     - state=IDLE; shift reg, bit counter and gap counter = 0.
//     - ser_out, ser_valid, ser_first, ser_last, busy and done all read 0.
//     - in_ready is forced to 0 while reset_n=0.
//   - States:
//     - IDLE: in_ready=1. Accept = in_valid & in_ready.
//     - SHIFT: ser_valid=1. ser_out = sreg[0].
//     - GAP: counts GAP_CYCLES cycles with ser_valid=0 and in_ready=0.
//   - Accept at edge k:
//     - sreg <= in_data, cnt <= 0, state <= SHIFT.
//     - Bit 0 appears in the cycle after edge k (1-cycle latency).
//   - SHIFT, bit advance: when ser_ready=1 at an edge, sreg <= {1'b0, sreg[WIDTH-1:1]} and cnt <= cnt+1.
//   - SHIFT, stall: when ser_ready=0, sreg and cnt hold and ser_out is stable.
//   - ser_first = SHIFT & (cnt==0). ser_last = SHIFT & (cnt==WIDTH-1).
//   - Frame end = last bit consumed (ser_last & ser_ready at the edge). At that edge:
//     - done <= 1 for exactly one cycle.
//     - GAP_CYCLES>0: state <= GAP, gap counter loaded.
//     - GAP_CYCLES==0: state <= IDLE.
//   - Back-to-back (GAP_CYCLES==0 only):
//     - in_ready is also 1 in SHIFT when ser_last & ser_ready.
//     - An accept at that edge loads the new word and restarts at cnt=0 with no ser_valid bubble.
//   - GAP: leaves to IDLE after exactly GAP_CYCLES cycles.
//   - abort=1 at any edge outside reset:
//     - state <= IDLE, sreg <= 0, counters <= 0, done <= 0.
//     - in_ready is 0 in the abort cycle, so no word is accepted.
//     - abort has priority over ser_ready and in_valid; reset_n has priority over abort.
//   - in_valid while busy (not ready) is ignored. in_data changes after accept do not affect the frame.
//   - Width rules:
//     - cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1; no wrap within a frame.
//     - The gap counter is $clog2(GAP_CYCLES+1) bits.
// TESTING
//   1. Basic frame: WIDTH=4, GAP=1, ser_ready=1, accept 4'b1010.
//      -> ser_out 0,1,0,1 on 4 consecutive cycles; first on bit 0, last on bit 3.
//      -> done pulse the next cycle; in_ready low 1 gap cycle, then high.
//   2. Stall: ser_ready=0 for 3 cycles while bit 1 is presented.
//      -> ser_out=1 and ser_valid=1 held; frame completes 3 cycles late with data intact.
//   3. Back-to-back: GAP=0, in_valid held with 4'b1010 then 4'b1110.
//      -> 8 consecutive valid bits 0,1,0,1,0,1,1,1; two done pulses; no bubble.
//   4. Reset mid-frame: reset_n=0 after bit 1.
//      -> all outputs 0 next cycle; after release in_ready=1 and a new 4'b0011 frame is sent correctly.
//   5. Abort during bit 2.
//      -> ser_valid=0 next cycle, no done, in_ready=1 the cycle after; the next frame starts at bit 0.
//   6. in_valid=1 with changing in_data while busy.
//      -> no extra accept; the transmitted bits match the originally accepted word only.

Source files
------------

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl
//   Sequencing controller around a WIDTH-bit parallel-in/serial-out shift
//   register. It accepts parallel words over a valid/ready handshake, shifts
//   each word out LSB first at the pace set by ser_ready, and flags the first
//   and last bit of every frame. After each frame it holds off the producer
//   for GAP_CYCLES idle cycles. With GAP_CYCLES == 0, frames run back-to-back
//   with no gap between them.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous, active-low reset
//   in_valid   producer has a word on in_data
//   in_data    parallel word, sampled only on accept
//   in_ready   controller can accept a word this cycle
//   ser_ready  downstream consumes the current bit this cycle
//   ser_out    current serial bit
//   ser_valid  ser_out holds a valid frame bit
//   ser_first  current bit is bit 0 of the frame
//   ser_last   current bit is bit WIDTH-1 of the frame
//   busy       controller is not idle
//   done       one-cycle pulse after the last bit is consumed
//   abort      synchronous frame cancel
module piso_tx_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic             done,
  input  logic             abort
);

  localparam int CW = $clog2(WIDTH);
  // A zero-width gap counter is illegal, so the back-to-back build keeps one
  // unused bit.
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam bit BACK_TO_BACK = (GAP_CYCLES == 0);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gap_cnt;
  logic             done_q;

  logic last_bit;
  logic frame_end;
  logic accept;

  assign last_bit  = (state == SHIFT) && (cnt == LAST_IDX);
  assign frame_end = last_bit && ser_ready;

  // NOTE: in_ready is a pure combinational decode with every term always
  // assigned, so no latch is inferred. It is gated by reset_n and abort
  // because neither condition may accept a word.
  assign in_ready = reset_n && !abort &&
                    ((state == IDLE) || (BACK_TO_BACK && frame_end));
  assign accept   = in_valid && in_ready;

  // NOTE: all state updates use non-blocking assignments. Every register
  // therefore sees the pre-edge values of the others, which matches the
  // hardware.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      done_q  <= 1'b0;
    end else if (abort) begin
      // abort outranks ser_ready and in_valid; the frame is dropped silently
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (cnt == LAST_IDX) begin
              done_q <= 1'b1;
              cnt    <= '0;
              if (accept) begin
                // back-to-back: the next word follows with no bubble
                sreg  <= in_data;
                state <= SHIFT;
              end else if (!BACK_TO_BACK) begin
                sreg    <= '0;
                gap_cnt <= GAP_LOAD;
                state   <= GAP;
              end else begin
                sreg  <= '0;
                state <= IDLE;
              end
            end else begin
              sreg <= {1'b0, sreg[WIDTH-1:1]};
              cnt  <= cnt + CW'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt <= GW'(1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches them.
  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid && sreg[0];
  assign ser_first = ser_valid && (cnt == '0);
  assign ser_last  = last_bit;
  assign busy      = (state != IDLE);
  assign done      = done_q;

endmodule
